// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the round-robin mux scheduler.
//   - FSM state encoding (IDLE, SELECT, HOLD)
//   - sizing constants for the 31-input, 2-bit mux
//   - onehot/next_idx helpers used by the top and the picker
package mux_sched_pkg;

  localparam int NUM_REQ = 31;
  localparam int SEL_W   = 5;
  localparam int DATA_W  = 2;
  localparam logic [SEL_W-1:0] SEL_MAX = 5'd30;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Successor of a requester index with wrap SEL_MAX -> 0.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return (idx >= SEL_MAX) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Bundle of scheduler-facing signals.
//   enable, req, mux_out, out_ready : into the scheduler
//   ack, sel, out_valid, out_data,
//   out_src, busy                   : out of the scheduler
// master = scheduler side, slave = requesters / mux / downstream side.
interface mux_rr_scheduler_if;
  import mux_sched_pkg::*;

  logic                 enable;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   ack;
  logic [SEL_W-1:0]     sel;
  logic [DATA_W-1:0]    mux_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [SEL_W-1:0]     out_src;
  logic                 busy;

  modport master (
    input  enable, req, mux_out, out_ready,
    output ack, sel, out_valid, out_data, out_src, busy
  );

  modport slave (
    output enable, req, mux_out, out_ready,
    input  ack, sel, out_valid, out_data, out_src, busy
  );

endinterface

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_grant : previous winner; search starts just after it
//   mask       : requests to ignore this search
//   found      : at least one unmasked request
//   winner     : first unmasked request at or after last_grant+1 (with wrap)
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last_grant,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [SEL_W-1:0]   winner
);

  localparam logic [SEL_W:0] WRAP = (SEL_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   offset;
  logic [SEL_W:0]     sum;

  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // conditional assignment, otherwise synthesis infers a latch.
    offset = '0;
    cand   = req & ~mask;
    start  = next_idx(last_grant);
    // Rotating a doubled copy puts the search start at bit 0, so the
    // lowest set bit of the low half is the round-robin winner.
    rot    = NUM_REQ'({cand, cand} >> start);
    found  = |rot;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = SEL_W'(i);
    end
    sum    = {1'b0, start} + {1'b0, offset};
    winner = (sum >= WRAP) ? SEL_W'(sum - WRAP) : SEL_W'(sum);
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler in front of a 31-input, 2-bit mux.
// Registers a grant onto sel, captures mux_out one cycle later, presents it
// on a valid/ready port and pulses ack to the winning requester.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : mux_rr_scheduler_if.master (req/ack, sel/mux_out, out_* port)
module mux_rr_scheduler
  import mux_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  mux_rr_scheduler_if.master   bus
);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]     out_src_q, out_src_d;
  logic [SEL_W-1:0]     last_grant_q, last_grant_d;

  logic                 pick_found;
  logic [SEL_W-1:0]     pick_winner;
  logic [NUM_REQ-1:0]   pick_mask;

  // In HOLD the current winner may still have req high; masking it stops a
  // second grant to the same requester on the handshake cycle.
  assign pick_mask = (state_q == HOLD) ? onehot(last_grant_q) : '0;

  rr_pick u_pick (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .mask       (pick_mask),
    .found      (pick_found),
    .winner     (pick_winner)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    ack_d        = '0;            // ack is a single-cycle pulse
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;

    unique case (state_q)
      IDLE: begin
        if (bus.enable && pick_found) begin
          sel_d   = pick_winner;
          state_d = SELECT;
        end
      end
      SELECT: begin
        out_data_d   = bus.mux_out;
        out_src_d    = sel_q;
        out_valid_d  = 1'b1;
        ack_d        = onehot(sel_q);
        last_grant_d = sel_q;
        state_d      = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (bus.enable && pick_found) begin
            sel_d   = pick_winner;
            state_d = SELECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to the top index so the first search begins at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      ack_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= SEL_MAX;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      sel_q        <= sel_d;
      ack_q        <= ack_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.ack       = ack_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler. Directed stimulus pushes expected
// transfers into a queue; a negedge monitor pops one per out_valid&&out_ready
// handshake. Directed checks cover reset, latency, ack pulses and stalls.
module tb_mux_rr_scheduler;
  import mux_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_rr_scheduler_if bus ();

  // Mux model: 32 entries so any 5-bit sel indexes in range.
  logic [DATA_W-1:0] mux_in [0:31];
  assign bus.mux_out = mux_in[bus.sel];

  mux_rr_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [SEL_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } xfer_t;

  xfer_t exp_q [$];
  xfer_t mon_e;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] b(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic xfer_t mk(input int s, input logic [DATA_W-1:0] d);
    xfer_t x;
    x.src  = SEL_W'(s);
    x.data = d;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("xfer_src", 64'(bus.out_src), 64'(mon_e.src));
        check("xfer_data", 64'(bus.out_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int rr_order [5] = '{0, 5, 30, 0, 5};

  initial begin
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) mux_in[i] = 2'b00;
    mux_in[0]  = 2'b01;
    mux_in[3]  = 2'b10;
    mux_in[5]  = 2'b10;
    mux_in[7]  = 2'b01;
    mux_in[9]  = 2'b11;
    mux_in[12] = 2'b01;
    mux_in[30] = 2'b11;

    // Reset state
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ack", 64'(bus.ack), 64'd0);
    check("rst_sel", 64'(bus.sel), 64'd0);
    check("rst_out_src", 64'(bus.out_src), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single request: req[5], data 2'b10
    tick();
    bus.enable = 1'b1; bus.out_ready = 1'b1; bus.req = b(5);
    exp_q.push_back(mk(5, 2'b10));
    smp(); check("single_c0_busy", 64'(bus.busy), 64'd0);
    tick(); smp();
    check("single_c1_sel", 64'(bus.sel), 64'd5);
    check("single_c1_valid", 64'(bus.out_valid), 64'd0);
    check("single_c1_ack", 64'(bus.ack), 64'd0);
    tick(); smp();
    check("single_c2_valid", 64'(bus.out_valid), 64'd1);
    check("single_c2_data", 64'(bus.out_data), 64'(2'b10));
    check("single_c2_src", 64'(bus.out_src), 64'd5);
    check("single_c2_ack", 64'(bus.ack), 64'(b(5)));
    tick(); bus.req = '0; smp();
    check("single_c3_ack", 64'(bus.ack), 64'd0);
    check("single_c3_valid", 64'(bus.out_valid), 64'd0);
    check("single_c3_busy", 64'(bus.busy), 64'd0);

    // Round-robin from reset: bits 0, 5, 30 held high
    tick();
    reset = 1'b1; #2; reset = 1'b0;
    bus.req = b(0) | b(5) | b(30);
    exp_q.push_back(mk(0, 2'b01));
    exp_q.push_back(mk(5, 2'b10));
    exp_q.push_back(mk(30, 2'b11));
    exp_q.push_back(mk(0, 2'b01));
    exp_q.push_back(mk(5, 2'b10));
    smp(); check("rr_c0_busy", 64'(bus.busy), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick(); smp();
      check("rr_select_sel", 64'(bus.sel), 64'(rr_order[k]));
      check("rr_select_valid", 64'(bus.out_valid), 64'd0);
      tick();
      if (k == 4) bus.req = '0;
      smp();
      check("rr_hold_valid", 64'(bus.out_valid), 64'd1);
      check("rr_hold_src", 64'(bus.out_src), 64'(rr_order[k]));
      check("rr_hold_ack", 64'(bus.ack), 64'(b(rr_order[k])));
    end
    tick(); smp(); check("rr_end_busy", 64'(bus.busy), 64'd0);

    // Wrap-around: first make last_grant = 30, then req 0 and 30
    tick(); bus.req = b(30); exp_q.push_back(mk(30, 2'b11)); smp();
    tick(); smp(); check("wrap_pre_sel", 64'(bus.sel), 64'd30);
    tick(); smp(); check("wrap_pre_src", 64'(bus.out_src), 64'd30);
    tick(); bus.req = '0; smp(); check("wrap_pre_idle", 64'(bus.busy), 64'd0);
    tick(); bus.req = b(0) | b(30);
    exp_q.push_back(mk(0, 2'b01));
    exp_q.push_back(mk(30, 2'b11));
    smp();
    tick(); smp(); check("wrap_sel0", 64'(bus.sel), 64'd0);
    tick(); smp(); check("wrap_src0", 64'(bus.out_src), 64'd0);
    tick(); smp(); check("wrap_sel30", 64'(bus.sel), 64'd30);
    tick(); bus.req = '0; smp();
    check("wrap_src30", 64'(bus.out_src), 64'd30);
    check("wrap_ack30", 64'(bus.ack), 64'(b(30)));
    tick(); smp(); check("wrap_end_busy", 64'(bus.busy), 64'd0);

    // Backpressure: 10 stalled HOLD cycles with mux_out toggling
    tick(); bus.req = b(7) | b(9); bus.out_ready = 1'b0;
    exp_q.push_back(mk(7, 2'b01));
    smp();
    tick(); smp(); check("bp_sel", 64'(bus.sel), 64'd7);
    tick(); smp();
    check("bp_first_ack", 64'(bus.ack), 64'(b(7)));
    check("bp_first_data", 64'(bus.out_data), 64'(2'b01));
    for (int s = 0; s < 10; s++) begin
      tick();
      if (s == 0) bus.req = b(9);
      mux_in[7] = ~mux_in[7];
      smp();
      check("bp_stall_data", 64'(bus.out_data), 64'(2'b01));
      check("bp_stall_src", 64'(bus.out_src), 64'd7);
      check("bp_stall_sel", 64'(bus.sel), 64'd7);
      check("bp_stall_valid", 64'(bus.out_valid), 64'd1);
      check("bp_stall_ack", 64'(bus.ack), 64'd0);
    end
    exp_q.push_back(mk(9, 2'b11));
    tick(); bus.out_ready = 1'b1; smp();
    check("bp_release_valid", 64'(bus.out_valid), 64'd1);
    tick(); smp();
    check("bp_next_sel", 64'(bus.sel), 64'd9);
    check("bp_next_valid", 64'(bus.out_valid), 64'd0);
    tick(); smp();
    check("bp_next_src", 64'(bus.out_src), 64'd9);
    check("bp_next_ack", 64'(bus.ack), 64'(b(9)));
    tick(); bus.req = '0; smp(); check("bp_end_busy", 64'(bus.busy), 64'd0);

    // Enable gating in IDLE; sel keeps its last value
    tick(); bus.enable = 1'b0; bus.req = b(3);
    for (int c = 0; c < 4; c++) begin
      tick(); smp();
      check("en_idle_busy", 64'(bus.busy), 64'd0);
      check("en_idle_sel", 64'(bus.sel), 64'd9);
    end
    // Enable dropped during HOLD: transfer completes, then IDLE
    tick(); bus.enable = 1'b1; exp_q.push_back(mk(3, 2'b10)); smp();
    tick(); smp(); check("en_sel", 64'(bus.sel), 64'd3);
    tick(); bus.req = b(3) | b(4); bus.enable = 1'b0; bus.out_ready = 1'b0; smp();
    check("en_hold_valid", 64'(bus.out_valid), 64'd1);
    check("en_hold_ack", 64'(bus.ack), 64'(b(3)));
    tick(); bus.out_ready = 1'b1; smp();
    check("en_hold2_busy", 64'(bus.busy), 64'd1);
    tick(); smp();
    check("en_after_busy", 64'(bus.busy), 64'd0);
    check("en_after_valid", 64'(bus.out_valid), 64'd0);
    bus.req = '0;

    // Asynchronous reset mid-HOLD: transfer discarded, no clock edge needed
    tick(); bus.enable = 1'b1; bus.req = b(12); bus.out_ready = 1'b0; smp();
    tick(); smp(); check("rh_sel", 64'(bus.sel), 64'd12);
    tick(); smp();
    check("rh_valid", 64'(bus.out_valid), 64'd1);
    check("rh_ack", 64'(bus.ack), 64'(b(12)));
    #2; reset = 1'b1; #1;
    check("rh_rst_valid", 64'(bus.out_valid), 64'd0);
    check("rh_rst_ack", 64'(bus.ack), 64'd0);
    check("rh_rst_sel", 64'(bus.sel), 64'd0);
    check("rh_rst_src", 64'(bus.out_src), 64'd0);
    check("rh_rst_busy", 64'(bus.busy), 64'd0);
    bus.req = '0;
    #1; reset = 1'b0;
    tick(); smp(); check("rh_post_busy", 64'(bus.busy), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares the 31-input, 2-bit selector mux among 31 requesters.
- Drives the mux `sel` from a registered grant and captures the mux output one cycle later.
- Presents each captured transfer on a valid/ready output port and acks the winning requester.
- Sits directly in front of the mux: its `sel` feeds the mux select, and the mux `out` returns on `mux_out`.

Parameters:
- NUM_REQ, 31, number of requesters / mux inputs; legal sel range 0..NUM_REQ-1.
- SEL_W, 5, width of sel and out_src.
- DATA_W, 2, width of mux data.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- enable  input  1  permits new arbitration from IDLE; does not abort an in-flight transfer.
- req  input  NUM_REQ  level request per mux input; bit i requests inp_i.
- ack  output  NUM_REQ  one-hot, one-cycle pulse to the granted requester.
- sel  output  SEL_W  registered select to the mux.
- mux_out  input  DATA_W  combinational mux output.
- out_valid  output  1  captured data available.
- out_ready  input  1  downstream accepts when high with out_valid.
- out_data  output  DATA_W  captured mux data.
- out_src  output  SEL_W  index the data came from.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset values: state=IDLE, sel=0, ack=0, out_valid=0, out_data=0, out_src=0, last_grant=NUM_REQ-1 (so the first search starts at 0).
- Arbitration:
  - Search req starting at (last_grant+1) mod NUM_REQ, ascending with wrap 30->0.
  - The first set bit wins.
  - The winner is always in 0..30; sel=31 is never driven.
- State machine:
  - IDLE: if enable && |req, register winner into sel and go to SELECT. Otherwise stay; sel holds its last value.
  - SELECT: sel is stable for this full cycle. At its end:
    - out_data<=mux_out, out_src<=sel, out_valid<=1;
    - ack<=onehot(sel), last_grant<=sel;
    - go to HOLD.
  - HOLD: out_valid=1. ack is high only in the first HOLD cycle and zero afterwards.
    - Stall (out_ready=0): out_data, out_src and sel hold; no new ack.
    - Handshake (out_ready=1), arbitrate over req & ~onehot(last_grant):
      - if any bit is set and enable=1: sel<=winner, out_valid<=0, go to SELECT;
      - else: out_valid<=0, go to IDLE.
- Latency: request seen in IDLE at cycle 0 -> sel valid in cycle 1 -> out_valid and ack in cycle 2.
- Throughput: back-to-back throughput is one transfer per 2 cycles.
- Requesters drop req the cycle after ack. Masking the current winner in HOLD prevents a double grant if ack and out_ready coincide.
- Requester withdrawal: a req dropped before it is granted is simply skipped. A req dropped after the SELECT capture does not cancel the transfer.
- enable=0 in HOLD: the current transfer completes, then the block returns to IDLE.
- reset mid-operation: all outputs return to reset values asynchronously. Any in-flight datum is discarded and no ack is issued.
- No combinational path from req or out_ready to any output.

Decomposition:
- Package mux_sched_pkg holds:
  - state enum {IDLE, SELECT, HOLD}, 2 bits;
  - constants NUM_REQ=31, SEL_W=5, DATA_W=2, SEL_MAX=30.
- Sub-module rr_pick, combinational:
  - inputs: req vector, last_grant pointer, mask vector;
  - outputs: found flag and winner index;
  - implementation: double-width rotate plus priority encode.
- The top holds the FSM and the registers.

Test Plan:
- Reset: assert reset mid-HOLD with out_valid=1 -> out_valid, ack, sel and out_src go to 0 without waiting for a clock edge; busy=0.
- Single request:
  - Stimulus: req[5]=1, mux_out=2'b10.
  - Required response: sel=5 in cycle 1; cycle 2 out_valid=1, out_data=2'b10, out_src=5, ack=1<<5 for exactly one cycle.
- Round-robin order: req bits 0, 5 and 30 held high, out_ready=1 -> grant order 0, 5, 30, 0, 5, with transfers every 2 cycles.
- Wrap-around: last_grant=30, req[30]=1 and req[0]=1 -> grant 0 next, then 30.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles during HOLD while mux_out toggles.
  - Required response: out_data, out_src and sel stable; a single ack pulse; no second grant until out_ready=1.
- Enable gating:
  - enable=0 with req[3]=1 -> stays IDLE, busy=0.
  - Deassert enable during HOLD -> the transfer completes, then IDLE.
